// File: rtl/klotski_move_tile.sv
// klotski_move_tile: walks one numbered tile of the 4x4 puzzle to a
// destination cell, calling the zero mover to clear the cell ahead.
module klotski_move_tile #(
    parameter int MAX_STEPS  = 16,
    parameter int MZ_TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_klotski,
    input  logic [15:0] i_mask,
    input  logic [3:0]  i_number,
    input  logic [3:0]  i_dest,
    output logic        o_mz_start,
    output logic [63:0] o_mz_klotski,
    output logic [15:0] o_mz_mask,
    output logic [3:0]  o_mz_target,
    output logic        o_mz_flag,
    output logic [3:0]  o_mz_num_pos,
    input  logic [63:0] i_mz_klotski,
    input  logic        i_mz_finished,
    output logic [63:0] o_klotski,
    output logic        o_finished,
    output logic        o_error
);

    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int TW = $clog2(MZ_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOCATE, S_CHECK, S_PLAN,
        S_REQ, S_WAIT, S_SWAP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   board_q, board_d;
    logic [15:0]   mask_q, mask_d;
    logic [3:0]    num_q, num_d;
    logic [3:0]    dest_q, dest_d;
    logic [3:0]    pos_q, pos_d;
    logic [3:0]    next_q, next_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    logic          found;
    logic [3:0]    loc_pos;
    logic [1:0]    tr, tc, dr, dc, rstep, cstep;
    logic [3:0]    row_cell, col_cell, plan_cell;
    logic          plan_ok;
    logic [TW-1:0] tmo_inc;

    // Locate the tile; a later cell overrides an earlier one.
    always_comb begin
        found   = 1'b0;
        loc_pos = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (board_q[4*k +: 4] == num_q) begin
                found   = 1'b1;
                loc_pos = 4'(k);
            end
        end
    end

    // Pick the next cell: row first, column as detour around a lock.
    always_comb begin
        tr        = pos_q[3:2];
        tc        = pos_q[1:0];
        dr        = dest_q[3:2];
        dc        = dest_q[1:0];
        rstep     = (dr > tr) ? tr + 2'd1 : tr - 2'd1;
        cstep     = (dc > tc) ? tc + 2'd1 : tc - 2'd1;
        row_cell  = {rstep, tc};
        col_cell  = {tr, cstep};
        plan_ok   = 1'b0;
        plan_cell = 4'd0;
        if (tr != dr) begin
            if (!mask_q[row_cell]) begin
                plan_ok   = 1'b1;
                plan_cell = row_cell;
            end else if (tc != dc && !mask_q[col_cell]) begin
                plan_ok   = 1'b1;
                plan_cell = col_cell;
            end
        end else if (!mask_q[col_cell]) begin
            plan_ok   = 1'b1;
            plan_cell = col_cell;
        end
    end

    assign tmo_inc = tmo_q + 1'b1;

    // Next-state and datapath updates for the move sequence.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        mask_d  = mask_q;
        num_d   = num_q;
        dest_d  = dest_q;
        pos_d   = pos_q;
        next_d  = next_q;
        step_d  = step_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    board_d = i_klotski;
                    mask_d  = i_mask;
                    num_d   = i_number;
                    dest_d  = i_dest;
                    step_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_LOCATE;
                end
            end
            S_LOCATE: begin
                if (found) begin
                    pos_d   = loc_pos;
                    state_d = S_CHECK;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                if (pos_q == dest_q) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (step_q == SW'(MAX_STEPS)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_PLAN;
                end
            end
            S_PLAN: begin
                if (!plan_ok) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    next_d = plan_cell;
                    if (board_q[{plan_cell, 2'b00} +: 4] == 4'h0)
                        state_d = S_SWAP;
                    else
                        state_d = S_REQ;
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_mz_finished) begin
                    board_d = i_mz_klotski;
                    state_d = S_SWAP;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TW'(MZ_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SWAP: begin
                if (board_q[{next_q, 2'b00} +: 4] != 4'h0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    board_d[{next_q, 2'b00} +: 4] = num_q;
                    board_d[{pos_q, 2'b00} +: 4]  = 4'h0;
                    pos_d = next_q;
                    if (step_q != '1)
                        step_d = step_q + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            board_q <= '0;
            mask_q  <= '0;
            num_q   <= '0;
            dest_q  <= '0;
            pos_q   <= '0;
            next_q  <= '0;
            step_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            mask_q  <= mask_d;
            num_q   <= num_d;
            dest_q  <= dest_d;
            pos_q   <= pos_d;
            next_q  <= next_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    logic mz_busy;
    assign mz_busy      = (state_q == S_REQ) || (state_q == S_WAIT);
    assign o_mz_start   = (state_q == S_REQ);
    assign o_mz_klotski = board_q;
    assign o_mz_mask    = mz_busy ? (mask_q | (16'h1 << pos_q)) : 16'h0;
    assign o_mz_target  = next_q;
    assign o_mz_flag    = 1'b0;
    assign o_mz_num_pos = pos_q;
    assign o_klotski    = board_q;
    assign o_finished   = (state_q == S_DONE);
    assign o_error      = o_finished & err_q;

endmodule

// File: tb/tb_klotski_move_tile.sv
// tb_klotski_move_tile: scoreboard bench with a behavioural move model
// and a zero-mover responder.
module tb_klotski_move_tile;

    localparam int MAX_STEPS  = 5;
    localparam int MZ_TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] kl = '0;
    logic [15:0] mask = '0;
    logic [3:0]  num = '0;
    logic [3:0]  dest = '0;
    logic [63:0] mzk = '0;
    logic        mzf = 1'b0;

    logic        o_mz_start;
    logic [63:0] o_mz_klotski;
    logic [15:0] o_mz_mask;
    logic [3:0]  o_mz_target;
    logic        o_mz_flag;
    logic [3:0]  o_mz_num_pos;
    logic [63:0] o_klotski;
    logic        o_finished;
    logic        o_error;

    klotski_move_tile #(.MAX_STEPS(MAX_STEPS), .MZ_TIMEOUT(MZ_TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_klotski(kl), .i_mask(mask), .i_number(num), .i_dest(dest),
        .o_mz_start(o_mz_start), .o_mz_klotski(o_mz_klotski),
        .o_mz_mask(o_mz_mask), .o_mz_target(o_mz_target),
        .o_mz_flag(o_mz_flag), .o_mz_num_pos(o_mz_num_pos),
        .i_mz_klotski(mzk), .i_mz_finished(mzf),
        .o_klotski(o_klotski), .o_finished(o_finished), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] board;
        logic        err;
        int          mz;
        int          lk;
    } exp_t;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] pos;
    } req_t;

    exp_t        sbq[$];
    req_t        rq[$];
    int          mz_mode = 0;
    int          mz_delay = 0;
    int          mz_seen = 0;
    int          start_cyc = 0;
    int          mz_cyc = 0;
    int          fin_cnt = 0;
    logic [15:0] cur_mask = '0;
    logic [63:0] last_board = '0;

    // Reference: walk the tile cell by cell using row/column arithmetic.
    task automatic model(input logic [63:0] bin, input logic [15:0] m,
                         input logic [3:0] n, input logic [3:0] d,
                         input int mode, output logic [63:0] bout,
                         output logic err, output int mzc);
        int b[16];
        int pos, steps, r, c, dr, dc, first, alt, nx, z;
        req_t q;
        for (int k = 0; k < 16; k++) b[k] = int'(bin[4*k +: 4]);
        pos = -1;
        for (int k = 0; k < 16; k++) if (b[k] == int'(n)) pos = k;
        err = 1'b1;
        mzc = 0;
        steps = 0;
        dr = int'(d) / 4;
        dc = int'(d) % 4;
        while (pos >= 0) begin
            if (pos == int'(d)) begin
                err = 1'b0;
                break;
            end
            if (steps == MAX_STEPS) break;
            r = pos / 4;
            c = pos % 4;
            alt = -1;
            if (r != dr) begin
                first = (r + ((dr > r) ? 1 : -1)) * 4 + c;
                if (c != dc) alt = r * 4 + c + ((dc > c) ? 1 : -1);
            end else begin
                first = r * 4 + c + ((dc > c) ? 1 : -1);
            end
            if (!m[first]) nx = first;
            else if (alt >= 0 && !m[alt]) nx = alt;
            else break;
            if (b[nx] != 0) begin
                q.tgt = 4'(nx);
                q.pos = 4'(pos);
                rq.push_back(q);
                mzc++;
                if (mode == 1) break;
                if (mode == 0) begin
                    z = -1;
                    for (int k = 0; k < 16; k++) if (b[k] == 0) z = k;
                    if (z >= 0) begin
                        b[z] = b[nx];
                        b[nx] = 0;
                    end
                end
                if (b[nx] != 0) break;
            end
            b[nx] = int'(n);
            b[pos] = 0;
            pos = nx;
            steps++;
        end
        for (int k = 0; k < 16; k++) bout[4*k +: 4] = 4'(b[k]);
    endtask

    // Zero-mover responder: mode 0 moves blank to target,
    // mode 1 never answers, mode 2 answers with the board unchanged.
    initial begin
        logic [63:0] nb;
        int z, dly;
        req_t q;
        forever begin
            @(negedge clk);
            if (rst_n && o_mz_start) begin
                mz_seen++;
                mz_cyc = cyc;
                chk("mz_flag", 64'(o_mz_flag), 64'd0);
                if (rq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL mz_unexpected: got target %0d expected none",
                             o_mz_target);
                end else begin
                    q = rq.pop_front();
                    chk("mz_target", 64'(o_mz_target), 64'(q.tgt));
                    chk("mz_num_pos", 64'(o_mz_num_pos), 64'(q.pos));
                    chk("mz_mask", 64'(o_mz_mask),
                        64'(cur_mask | (16'h1 << q.pos)));
                end
                if (mz_mode != 1) begin
                    nb = o_mz_klotski;
                    if (mz_mode == 0) begin
                        z = -1;
                        for (int k = 0; k < 16; k++)
                            if (nb[4*k +: 4] == 4'h0) z = k;
                        if (z >= 0) begin
                            nb[4*z +: 4] = nb[4*o_mz_target +: 4];
                            nb[4*o_mz_target +: 4] = 4'h0;
                        end
                    end
                    dly = (mz_delay > 0) ? mz_delay : int'($urandom_range(1, 4));
                    repeat (dly) @(negedge clk);
                    mzk = nb;
                    mzf = 1'b1;
                    @(negedge clk);
                    mzf = 1'b0;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every o_finished.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_finished) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL finish_unexpected: got o_finished expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("board", o_klotski, e.board);
                    chk("error", 64'(o_error), 64'(e.err));
                    chk("mz_count", 64'(mz_seen), 64'(e.mz));
                    if (e.lk == 1)
                        chk("latency_start", 64'(cyc - start_cyc), 64'd3);
                    if (e.lk == 2)
                        chk("latency_timeout", 64'(cyc - mz_cyc),
                            64'(MZ_TIMEOUT + 1));
                    last_board = e.board;
                end
                fin_cnt++;
            end
        end
    end

    task automatic issue(input logic [63:0] b, input logic [15:0] m,
                         input logic [3:0] n, input logic [3:0] d,
                         input int mode);
        @(negedge clk);
        mz_mode = mode;
        cur_mask = m;
        mz_seen = 0;
        kl = b;
        mask = m;
        num = n;
        dest = d;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [63:0] b, input logic [15:0] m,
                       input logic [3:0] n, input logic [3:0] d,
                       input int mode, input int lk);
        exp_t e;
        int f0, t;
        model(b, m, n, d, mode, e.board, e.err, e.mz);
        e.lk = lk;
        sbq.push_back(e);
        f0 = fin_cnt;
        issue(b, m, n, d, mode);
        t = 0;
        while (fin_cnt == f0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (fin_cnt == f0) begin
            n_chk++;
            n_fail++;
            $display("FAIL finish_timeout: got no o_finished expected one");
            sbq.delete();
        end
        rq.delete();
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] solved();
        logic [63:0] b;
        for (int k = 0; k < 16; k++) b[4*k +: 4] = 4'((k + 1) % 16);
        return b;
    endfunction

    function automatic logic [63:0] rand_perm();
        int a[16];
        int j, tmp;
        logic [63:0] b;
        for (int k = 0; k < 16; k++) a[k] = k;
        for (int k = 15; k > 0; k--) begin
            j = int'($urandom_range(0, k));
            tmp = a[k];
            a[k] = a[j];
            a[j] = tmp;
        end
        for (int k = 0; k < 16; k++) b[4*k +: 4] = 4'(a[k]);
        return b;
    endfunction

    initial begin
        logic [63:0] b;
        logic [15:0] m;
        exp_t        dummy;
        int          t, md;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(|{o_mz_start, o_mz_klotski, o_mz_mask,
            o_mz_target, o_mz_flag, o_mz_num_pos, o_klotski,
            o_finished, o_error}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 16; k++) b[4*k +: 4] = 4'(k);
        run(b, 16'h0, 4'd5, 4'h5, 0, 1);

        for (int k = 0; k < 11; k++) b[4*k +: 4] = 4'(k + 1);
        b[44 +: 4] = 4'h0;
        for (int k = 12; k < 16; k++) b[4*k +: 4] = 4'(k);
        run(b, 16'h0, 4'd15, 4'hB, 0, 0);

        mz_delay = 3;
        run(solved(), 16'h0, 4'd1, 4'h3, 0, 0);

        run(solved(), 16'h0, 4'd1, 4'h3, 1, 2);
        mz_delay = 0;

        run(solved(), 16'h0012, 4'd1, 4'h5, 0, 0);
        run(64'h0, 16'h0, 4'd7, 4'h2, 0, 0);

        b = 64'h0;
        b[8 +: 4]  = 4'd3;
        b[36 +: 4] = 4'd3;
        run(b, 16'h0, 4'd3, 4'h9, 0, 1);

        run(solved(), 16'h0, 4'd2, 4'h3, 2, 0);
        run(solved(), 16'h0, 4'd1, 4'hF, 0, 0);

        @(negedge clk);
        mzk = ~last_board;
        mzf = 1'b1;
        @(negedge clk);
        mzf = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_mz_ignored", o_klotski, last_board);

        model(solved(), 16'h0, 4'd1, 4'h3, 1, dummy.board, dummy.err, dummy.mz);
        issue(solved(), 16'h0, 4'd1, 4'h3, 1);
        t = 0;
        while (mz_seen == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reset_test_mz_seen", 64'(mz_seen), 64'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midop_reset_outputs", 64'(|{o_mz_start, o_mz_klotski,
            o_mz_mask, o_mz_target, o_mz_flag, o_mz_num_pos, o_klotski,
            o_finished, o_error}), 64'd0);
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(solved(), 16'h0, 4'd6, 4'h4, 0, 0);

        for (int i = 0; i < 40; i++) begin
            b = rand_perm();
            m = '0;
            for (int k = 0; k < 16; k++)
                m[k] = ($urandom_range(0, 5) == 0);
            md = ($urandom_range(0, 5) == 0) ? 2 : 0;
            run(b, m, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                md, 0);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
